// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// and a registered byte/strobe output that only changes on a good frame.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] d0,
  output logic       dv0,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    d0_q, d0_d;
  logic          dv0_q, dv0_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    d0_d      = d0_q;
    dv0_d     = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Counter is held at zero so the first START cycle counts as 0.
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s_q) begin
            d0_d    = shift_q;
            dv0_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line held low after a bad stop bit is one error, not a stream of them.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      d0_q      <= '0;
      dv0_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      d0_q      <= d0_d;
      dv0_q     <= dv0_d;
      ferr_q    <= ferr_d;
    end
  end

  assign d0        = d0_q;
  assign dv0       = dv0_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks/bit: the driver queues the
// expected byte/error and strobe cycle, the monitor pops on each strobe.
module tb_uart_rx;

  localparam int C = 16;
  localparam int STROBE_OFS = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] d0;
  logic       dv0;
  logic       frame_err;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .d0       (d0),
    .dv0      (dv0),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // Caller is aligned just after a rising edge; the frame's falling edge is driven now.
  task automatic send_frame(input logic [7:0] b, input int per, input logic stop_val);
    exp_t e;
    logic [9:0] bits;
    e.err  = ~stop_val;
    e.data = b;
    e.cyc  = cyc + STROBE_OFS;
    exp_q.push_back(e);
    bits = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (per) step();
    end
    $display("frame 0x%02h per=%0d stop=%0b queued, strobe expected at cycle %0d",
             b, per, stop_val, e.cyc);
  endtask

  initial begin : monitor
    logic [7:0] d0_prev;
    logic       rst_d;
    exp_t       e;
    d0_prev = 8'h00;
    rst_d   = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (dv0 || frame_err) begin
          check_eq("dv0_ferr_excl", {31'b0, dv0 & frame_err}, 32'd0);
          check_eq("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("strobe_kind", {31'b0, frame_err}, {31'b0, e.err});
            check_eq("strobe_cyc", cyc, e.cyc);
            if (!e.err) check_eq("d0_byte", {24'b0, d0}, {24'b0, e.data});
            $display("strobe at cycle %0d: dv0=%0b frame_err=%0b d0=0x%02h", cyc, dv0, frame_err, d0);
          end
        end
        if (!rst_d && !dv0 && (d0 !== d0_prev))
          check_eq("d0_hold", {24'b0, d0}, {24'b0, d0_prev});
      end
      d0_prev = d0;
      rst_d   = rst;
    end
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    check_eq("rst_d0", {24'b0, d0}, 32'h00);
    check_eq("rst_dv0", {31'b0, dv0}, 32'd0);
    check_eq("rst_ferr", {31'b0, frame_err}, 32'd0);
    mon_en = 1'b1;
    idle(10);

    // 1: single byte, then d0 must persist
    send_frame(8'hA5, C, 1'b1);
    idle(70);
    check_eq("a5_hold", {24'b0, d0}, 32'hA5);

    // 2: back-to-back frames, strobes 160 cycles apart
    send_frame(8'h00, C, 1'b1);
    send_frame(8'hFF, C, 1'b1);
    idle(20);
    check_eq("ff_d0", {24'b0, d0}, 32'hFF);

    // 4: bad stop bit with line held low, then recovery
    send_frame(8'h3C, C, 1'b0);
    rx = 1'b0;
    repeat (100) step();
    check_eq("ferr_d0_kept", {24'b0, d0}, 32'hFF);
    idle(20);
    send_frame(8'h81, C, 1'b1);
    idle(20);
    check_eq("81_d0", {24'b0, d0}, 32'h81);

    // 3: short glitch must be rejected, then a clean frame
    rx = 1'b0;
    repeat (3) step();
    idle(40);
    check_eq("glitch_sb_empty", exp_q.size(), 32'd0);
    send_frame(8'h3C, C, 1'b1);
    idle(20);
    check_eq("3c_d0", {24'b0, d0}, 32'h3C);

    // 5: reset in the middle of data bit 4 of 0xC3; the line goes idle afterwards
    begin
      logic [7:0] b;
      b = 8'hC3;
      rx = 1'b0;
      repeat (C) step();
      for (int k = 0; k < 4; k++) begin
        rx = b[k];
        repeat (C) step();
      end
      rx = b[4];
      repeat (C / 2) step();
      rst = 1'b1;
      rx  = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midrst_d0", {24'b0, d0}, 32'h00);
      check_eq("midrst_dv0", {31'b0, dv0}, 32'd0);
      check_eq("midrst_ferr", {31'b0, frame_err}, 32'd0);
    end
    idle(200);
    send_frame(8'h5A, C, 1'b1);
    idle(20);
    check_eq("5a_d0", {24'b0, d0}, 32'h5A);

    // 6: transmitter 6% slow
    send_frame(8'h96, C + 1, 1'b1);
    idle(30);
    check_eq("96_d0", {24'b0, d0}, 32'h96);

    check_eq("sb_empty_end", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
